prg_loader: RTL

- Front-end writer for the program memory that the brainhack core fetches from.
- Accepts an ASCII Brainfuck source stream over a valid/ready byte interface and drops non-command characters as comments.
- Encodes each command into the core's 3-bit instruction format, writes it to program memory, checks bracket balance and nesting depth, and pads unused locations with NOP.
- Asserts o_core_run once a valid image is loaded.

---
 rtl/prg_loader.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/prg_loader.sv
`default_nettype none
// ============================================================================
// Module   : prg_loader
// Purpose  : Streams ASCII Brainfuck source into the core's program memory.
//            Commands are encoded to 3-bit instructions, brackets are checked
//            for balance and nesting depth, unused locations are padded with
//            NOP, and o_core_run is raised once a valid image is in place.
// Revision : 1.0 - initial release
// ============================================================================
module prg_loader #(
  parameter int PRGMEM_ADDR_WIDTH = 8,
  parameter int STACK_ADDR_WIDTH  = 4
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_valid,
  input  logic [7:0]                   i_char,
  output logic                         o_ready,
  input  logic                         i_start,
  output logic                         o_prgmem_in,
  output logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr,
  output logic [2:0]                   o_prgmem_data,
  output logic [PRGMEM_ADDR_WIDTH:0]   o_length,
  output logic                         o_core_run,
  output logic                         o_error,
  output logic [1:0]                   o_err_code
);

  localparam logic [1:0] c_st_load  = 2'd0;
  localparam logic [1:0] c_st_pad   = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;
  localparam logic [1:0] c_st_error = 2'd3;

  localparam logic [1:0] c_err_unbal = 2'b01;
  localparam logic [1:0] c_err_deep  = 2'b10;
  localparam logic [1:0] c_err_long  = 2'b11;

  // Count and pad pointer carry one extra bit so that "memory full" (2^W)
  // is representable.
  localparam logic [PRGMEM_ADDR_WIDTH:0]  c_capacity  = {1'b1, {PRGMEM_ADDR_WIDTH{1'b0}}};
  localparam logic [PRGMEM_ADDR_WIDTH:0]  c_count_one = {{PRGMEM_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [STACK_ADDR_WIDTH-1:0] c_max_depth = {STACK_ADDR_WIDTH{1'b1}};
  localparam logic [STACK_ADDR_WIDTH-1:0] c_depth_one = {{(STACK_ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                   r_state;
  logic [1:0]                   w_state_next;
  logic [PRGMEM_ADDR_WIDTH:0]   r_count;
  logic [PRGMEM_ADDR_WIDTH:0]   w_count_next;
  logic [PRGMEM_ADDR_WIDTH:0]   r_pad_addr;
  logic [PRGMEM_ADDR_WIDTH:0]   w_pad_addr_next;
  logic [STACK_ADDR_WIDTH-1:0]  r_depth;
  logic [STACK_ADDR_WIDTH-1:0]  w_depth_next;
  logic [1:0]                   r_err_code;
  logic [1:0]                   w_err_code_next;
  logic                         r_wr_en;
  logic                         w_wr_en;
  logic [PRGMEM_ADDR_WIDTH-1:0] r_wr_addr;
  logic [PRGMEM_ADDR_WIDTH-1:0] w_wr_addr;
  logic [2:0]                   r_wr_data;
  logic [2:0]                   w_wr_data;

  logic       w_accept;
  logic       w_is_cmd;
  logic       w_is_open;
  logic       w_is_close;
  logic       w_is_term;
  logic [2:0] w_code;
  logic       w_err_long;
  logic       w_err_deep;
  logic       w_err_close;
  logic       w_err_term;
  logic       w_cmd_ok;
  logic       w_term_ok;
  logic       w_restart;

  assign o_ready  = (r_state == c_st_load);
  assign w_accept = i_valid && o_ready;

  // Decode the incoming byte into an instruction code; anything unknown is a comment.
  always_comb begin
    w_code   = 3'b000;
    w_is_cmd = 1'b1;
    case (i_char)
      8'h2B:   w_code = 3'b010;  // '+'
      8'h2D:   w_code = 3'b011;  // '-'
      8'h3E:   w_code = 3'b100;  // '>'
      8'h3C:   w_code = 3'b101;  // '<'
      8'h5B:   w_code = 3'b110;  // '['
      8'h5D:   w_code = 3'b111;  // ']'
      default: w_is_cmd = 1'b0;
    endcase
  end

  assign w_is_open  = (i_char == 8'h5B);
  assign w_is_close = (i_char == 8'h5D);
  assign w_is_term  = (i_char == 8'h00);

  // Length overflow takes precedence over bracket faults on the same byte.
  assign w_err_long  = w_accept && w_is_cmd && (r_count == c_capacity);
  assign w_err_deep  = w_accept && w_is_open && (r_depth == c_max_depth) && !w_err_long;
  assign w_err_close = w_accept && w_is_close && (r_depth == '0) && !w_err_long;
  assign w_err_term  = w_accept && w_is_term && (r_depth != '0);
  assign w_cmd_ok    = w_accept && w_is_cmd && !w_err_long && !w_err_deep && !w_err_close;
  assign w_term_ok   = w_accept && w_is_term && (r_depth == '0);
  assign w_restart   = i_start && ((r_state == c_st_done) || (r_state == c_st_error));

  // State, bookkeeping and registered write port.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= c_st_load;
      r_count    <= '0;
      r_pad_addr <= '0;
      r_depth    <= '0;
      r_err_code <= 2'b00;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 3'b000;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_pad_addr <= w_pad_addr_next;
      r_depth    <= w_depth_next;
      r_err_code <= w_err_code_next;
      r_wr_en    <= w_wr_en;
      r_wr_addr  <= w_wr_addr;
      r_wr_data  <= w_wr_data;
    end
  end

  // Next state and latched error code.
  always_comb begin
    w_state_next    = r_state;
    w_err_code_next = r_err_code;
    case (r_state)
      c_st_load: begin
        if (w_err_long) begin
          w_state_next    = c_st_error;
          w_err_code_next = c_err_long;
        end else if (w_err_deep) begin
          w_state_next    = c_st_error;
          w_err_code_next = c_err_deep;
        end else if (w_err_close || w_err_term) begin
          w_state_next    = c_st_error;
          w_err_code_next = c_err_unbal;
        end else if (w_term_ok) begin
          // A full image needs no padding.
          w_state_next = (r_count == c_capacity) ? c_st_done : c_st_pad;
        end
      end
      c_st_pad: begin
        // DONE follows the cycle after the last pad write has been issued.
        if (r_pad_addr == c_capacity) begin
          w_state_next = c_st_done;
        end
      end
      c_st_done, c_st_error: begin
        if (w_restart) begin
          w_state_next    = c_st_load;
          w_err_code_next = 2'b00;
        end
      end
      default: w_state_next = c_st_load;
    endcase
  end

  // Write requests, counters and depth; the first pad write is issued on the
  // same edge that accepts the terminator.
  always_comb begin
    w_wr_en         = 1'b0;
    w_wr_addr       = r_count[PRGMEM_ADDR_WIDTH-1:0];
    w_wr_data       = 3'b000;
    w_count_next    = r_count;
    w_pad_addr_next = r_pad_addr;
    w_depth_next    = r_depth;
    case (r_state)
      c_st_load: begin
        if (w_cmd_ok) begin
          w_wr_en      = 1'b1;
          w_wr_data    = w_code;
          w_count_next = r_count + c_count_one;
          if (w_is_open) begin
            w_depth_next = r_depth + c_depth_one;
          end else if (w_is_close) begin
            w_depth_next = r_depth - c_depth_one;
          end
        end else if (w_term_ok && (r_count != c_capacity)) begin
          w_wr_en         = 1'b1;
          w_pad_addr_next = r_count + c_count_one;
        end
      end
      c_st_pad: begin
        if (r_pad_addr != c_capacity) begin
          w_wr_en         = 1'b1;
          w_wr_addr       = r_pad_addr[PRGMEM_ADDR_WIDTH-1:0];
          w_pad_addr_next = r_pad_addr + c_count_one;
        end
      end
      default: begin
        if (w_restart) begin
          w_count_next    = '0;
          w_depth_next    = '0;
          w_pad_addr_next = '0;
        end
      end
    endcase
  end

  assign o_prgmem_in   = r_wr_en;
  assign o_prgmem_addr = r_wr_addr;
  assign o_prgmem_data = r_wr_data;
  assign o_length      = r_count;
  assign o_core_run    = (r_state == c_st_done);
  assign o_error       = (r_state == c_st_error);
  assign o_err_code    = r_err_code;

endmodule
`default_nettype wire
